// File: rtl/commit_stage_pkg.sv
// Shared definitions for the commit stage: instruction encodings and the
// commit FSM state type.
package common_def;

  // A bubble in the execute-commit register; commits but is not retired.
  localparam logic [11:0] NOP     = 12'h000;
  // Opcode field (instruction[11:8]) of the HALT instruction.
  localparam logic [3:0]  OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } commit_state_e;

  function automatic logic is_halt(input logic [11:0] instr);
    return instr[11:8] == OP_HALT;
  endfunction

endpackage

// File: rtl/commit_store_buffer.sv
// Store buffer FIFO between commit and data memory. The head address/data
// and the valid flag are registered, so the memory port sees clean
// register outputs that stay stable until the head is popped.
module commit_store_buffer
  import common_def::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic [9:0]  i_push_addr,
  input  logic [11:0] i_push_data,
  input  logic        i_pop,
  output logic [9:0]  o_head_addr,
  output logic [11:0] o_head_data,
  output logic        o_valid,
  output logic        o_full,
  output logic        o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [21:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [9:0]    r_head_addr;
  logic [11:0]   r_head_data;
  logic          r_valid;

  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_rd_nxt;
  logic [PW-1:0] w_wr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [21:0]   w_head_nxt;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  // Accept/pop qualification, next occupancy and the next head entry.
  always_comb begin
    w_push      = i_push && (r_count != FULL_CNT);
    w_pop       = i_pop && (r_count != '0);
    w_rd_nxt    = ptr_inc(r_rd_ptr);
    w_wr_nxt    = ptr_inc(r_wr_ptr);
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    w_head_nxt = {r_head_addr, r_head_data};
    if (w_count_nxt == '0) begin
      w_head_nxt = '0;
    end else if (r_count == '0) begin
      // Push into an empty buffer: the new entry becomes the head.
      w_head_nxt = {i_push_addr, i_push_data};
    end else if (w_pop) begin
      // With one entry left and a simultaneous push, the pushed entry is
      // the new head; otherwise the next stored entry moves up.
      if (r_count == CW'(1)) w_head_nxt = {i_push_addr, i_push_data};
      else                   w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // Control state: pointers, occupancy and the registered head view.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_head_addr <= '0;
      r_head_data <= '0;
      r_valid     <= 1'b0;
    end else begin
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      if (w_push) r_wr_ptr <= w_wr_nxt;
      r_count     <= w_count_nxt;
      r_head_addr <= w_head_nxt[21:12];
      r_head_data <= w_head_nxt[11:0];
      r_valid     <= (w_count_nxt != '0);
    end
  end

  // Entry storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_push_addr, i_push_data};
  end

  assign o_head_addr = r_head_addr;
  assign o_head_data = r_head_data;
  assign o_valid     = r_valid;
  assign o_full      = (r_count == FULL_CNT);
  assign o_empty     = (r_count == '0);

endmodule

// File: rtl/commit_stage.sv
// Commit stage: retires the instruction held in the execute-commit
// register, writes the register file, buffers stores toward data memory,
// counts retired instructions and handles HALT (drain stores, then stop).
module commit_stage
  import common_def::*;
#(
  parameter int SB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_store_EC,
  input  logic        reg_write_en_EC,
  input  logic [3:0]  reg_write_addr_EC,
  input  logic [11:0] execute_result_EC,
  input  logic [11:0] instruction_EC,
  input  logic [9:0]  pc_plus_1_EC,
  output logic        write_enable_EC,
  output logic        clear_EC,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [11:0] rf_wdata,
  output logic        dmem_req,
  output logic [9:0]  dmem_addr,
  output logic [11:0] dmem_wdata,
  input  logic        dmem_ack,
  output logic [15:0] instret,
  output logic        halted,
  output logic [9:0]  halt_pc
);

  commit_state_e r_state;
  commit_state_e w_state_nxt;

  logic        w_ready;
  logic        w_commit;
  logic        w_halt_commit;
  logic        w_push;
  logic        w_sb_full;
  logic        w_sb_empty;
  logic        w_sb_valid;
  logic [9:0]  w_head_addr;
  logic [11:0] w_head_data;
  logic [9:0]  w_push_addr;

  logic        r_rf_we;
  logic [3:0]  r_rf_waddr;
  logic [11:0] r_rf_wdata;
  logic [15:0] r_instret;
  logic        r_halted;
  logic [9:0]  r_halt_pc;

  assign w_push_addr = {2'b00, instruction_EC[7:0]};

  // Commit decision and FSM next state. A full buffer stalls only stores;
  // a pop in the same cycle does not free a slot early. Reset suppresses
  // commit so nothing is pushed, counted or flushed in a reset cycle.
  always_comb begin
    w_ready       = !(mem_store_EC && w_sb_full);
    w_commit      = !rst && (r_state == ST_RUN) && w_ready;
    w_halt_commit = w_commit && is_halt(instruction_EC);
    w_push        = w_commit && mem_store_EC;
    w_state_nxt   = r_state;
    case (r_state)
      ST_RUN:    if (w_halt_commit) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_sb_empty)    w_state_nxt = ST_HALTED;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Registered register-file write port, one cycle after commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_commit && reg_write_en_EC;
      if (w_commit && reg_write_en_EC) begin
        r_rf_waddr <= reg_write_addr_EC;
        r_rf_wdata <= execute_result_EC;
      end
    end
  end

  // Retired-instruction counter (bubbles excluded) and halt bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= '0;
      r_halted  <= 1'b0;
      r_halt_pc <= '0;
    end else begin
      if (w_commit && (instruction_EC != NOP)) r_instret <= r_instret + 16'd1;
      if (w_halt_commit) r_halt_pc <= pc_plus_1_EC;
      r_halted <= (w_state_nxt == ST_HALTED);
    end
  end

  commit_store_buffer #(
    .DEPTH (SB_DEPTH)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_addr (w_push_addr),
    .i_push_data (execute_result_EC),
    .i_pop       (dmem_ack),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_valid     (w_sb_valid),
    .o_full      (w_sb_full),
    .o_empty     (w_sb_empty)
  );

  assign write_enable_EC = w_commit;
  assign clear_EC        = w_halt_commit;
  assign rf_we           = r_rf_we;
  assign rf_waddr        = r_rf_waddr;
  assign rf_wdata        = r_rf_wdata;
  assign dmem_req        = w_sb_valid;
  assign dmem_addr       = w_head_addr;
  assign dmem_wdata      = w_head_data;
  assign instret         = r_instret;
  assign halted          = r_halted;
  assign halt_pc         = r_halt_pc;

endmodule

// File: tb/tb_commit_stage.sv
// Testbench for commit_stage: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the commit rules.
module tb_commit_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_store_EC;
  logic        reg_write_en_EC;
  logic [3:0]  reg_write_addr_EC;
  logic [11:0] execute_result_EC;
  logic [11:0] instruction_EC;
  logic [9:0]  pc_plus_1_EC;
  logic        write_enable_EC;
  logic        clear_EC;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [11:0] rf_wdata;
  logic        dmem_req;
  logic [9:0]  dmem_addr;
  logic [11:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] instret;
  logic        halted;
  logic [9:0]  halt_pc;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0=RUN 1=DRAIN 2=HALTED, stores as a queue.
  int          m_st;
  logic [21:0] m_q[$];
  logic        m_rf_we;
  logic [3:0]  m_rf_waddr;
  logic [11:0] m_rf_wdata;
  logic [15:0] m_instret;
  logic [9:0]  m_halt_pc;

  commit_stage #(.SB_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_store_EC      (mem_store_EC),
    .reg_write_en_EC   (reg_write_en_EC),
    .reg_write_addr_EC (reg_write_addr_EC),
    .execute_result_EC (execute_result_EC),
    .instruction_EC    (instruction_EC),
    .pc_plus_1_EC      (pc_plus_1_EC),
    .write_enable_EC   (write_enable_EC),
    .clear_EC          (clear_EC),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .dmem_req          (dmem_req),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_ack          (dmem_ack),
    .instret           (instret),
    .halted            (halted),
    .halt_pc           (halt_pc)
  );

  always #5 clk = ~clk;

  function automatic logic m_commit();
    return !rst && (m_st == 0) && !(mem_store_EC && m_q.size() == DEPTH);
  endfunction

  function automatic logic m_halt();
    return m_commit() && (instruction_EC[11:8] == 4'hF);
  endfunction

  task automatic set_bubble();
    mem_store_EC      = 1'b0;
    reg_write_en_EC   = 1'b0;
    reg_write_addr_EC = 4'h0;
    execute_result_EC = 12'h000;
    instruction_EC    = 12'h000;
    pc_plus_1_EC      = 10'h000;
  endtask

  task automatic set_store(input logic [7:0] a, input logic [11:0] d);
    set_bubble();
    mem_store_EC      = 1'b1;
    instruction_EC    = {4'h2, a};
    execute_result_EC = d;
  endtask

  // Advance one clock and apply the commit rules to the model.
  task automatic tick();
    logic c, h, p;
    c = m_commit();
    h = m_halt();
    p = dmem_ack && (m_q.size() > 0);
    @(posedge clk);
    if (rst) begin
      m_st = 0; m_q.delete();
      m_rf_we = 1'b0; m_rf_waddr = '0; m_rf_wdata = '0;
      m_instret = '0; m_halt_pc = '0;
    end else begin
      if (m_st == 0 && h) m_st = 1;
      else if (m_st == 1 && m_q.size() == 0) m_st = 2;
      if (p) void'(m_q.pop_front());
      if (c && mem_store_EC) m_q.push_back({2'b00, instruction_EC[7:0], execute_result_EC});
      m_rf_we = c && reg_write_en_EC;
      if (m_rf_we) begin
        m_rf_waddr = reg_write_addr_EC;
        m_rf_wdata = execute_result_EC;
      end
      if (c && instruction_EC != 12'h000) m_instret = m_instret + 16'd1;
      if (h) m_halt_pc = pc_plus_1_EC;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; dmem_ack = 1'b0; set_bubble();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({dmem_req, dmem_addr, dmem_wdata, rf_we, rf_waddr, rf_wdata, instret, halted, halt_pc, clear_EC} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: req=%b addr=%h wdata=%h rf_we=%b waddr=%h wdata=%h instret=%h halted=%b halt_pc=%h clear=%b required all zero",
               dmem_req, dmem_addr, dmem_wdata, rf_we, rf_waddr, rf_wdata, instret, halted, halt_pc, clear_EC);
    end
    n_vec++;
    if (write_enable_EC !== 1'b1) begin
      n_err++; $display("FAIL reset_we: got %b required 1", write_enable_EC);
    end
  endtask

  task automatic test_rf_write();
    set_bubble();
    instruction_EC = 12'h103; reg_write_en_EC = 1'b1;
    reg_write_addr_EC = 4'd3; execute_result_EC = 12'h0A5;
    tick();
    set_bubble(); #1;
    n_vec++;
    if ({rf_we, rf_waddr, rf_wdata, instret} !== {1'b1, 4'd3, 12'h0A5, 16'd1}) begin
      n_err++;
      $display("FAIL rf_write: got we=%b a=%h d=%h instret=%0d required we=1 a=3 d=0a5 instret=1", rf_we, rf_waddr, rf_wdata, instret);
    end
    tick();
    n_vec++;
    if (rf_we !== 1'b0) begin
      n_err++; $display("FAIL rf_we_pulse: got %b required 0", rf_we);
    end
  endtask

  task automatic test_store_hold();
    set_store(8'h40, 12'h123);
    tick();
    set_bubble(); dmem_ack = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({dmem_req, dmem_addr, dmem_wdata} !== {1'b1, 10'h040, 12'h123}) begin
        n_err++;
        $display("FAIL store_hold[%0d]: got req=%b addr=%h data=%h required req=1 addr=040 data=123", i, dmem_req, dmem_addr, dmem_wdata);
      end
      tick();
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0; #1;
    n_vec++;
    if (dmem_req !== 1'b0) begin
      n_err++; $display("FAIL store_pop: req got %b required 0", dmem_req);
    end
  endtask

  task automatic test_back_to_back();
    dmem_ack = 1'b0;
    set_store(8'h10, 12'h111); #1;
    n_vec++;
    if (write_enable_EC !== 1'b1) begin n_err++; $display("FAIL b2b_we1: got %b required 1", write_enable_EC); end
    tick();
    set_store(8'h20, 12'h222); #1;
    n_vec++;
    if (write_enable_EC !== 1'b1) begin n_err++; $display("FAIL b2b_we2: got %b required 1", write_enable_EC); end
    tick();
    set_store(8'h30, 12'h333); #1;
    n_vec++;
    if (write_enable_EC !== 1'b0) begin n_err++; $display("FAIL b2b_we3: got %b required 0", write_enable_EC); end
    tick();
    dmem_ack = 1'b1; #1;
    n_vec++;
    if (write_enable_EC !== 1'b0) begin n_err++; $display("FAIL b2b_pop_no_ready: got %b required 0", write_enable_EC); end
    n_vec++;
    if ({dmem_addr, dmem_wdata} !== {10'h010, 12'h111}) begin
      n_err++; $display("FAIL b2b_head_a: got %h/%h required 010/111", dmem_addr, dmem_wdata);
    end
    tick();
    dmem_ack = 1'b0; #1;
    n_vec++;
    if ({write_enable_EC, dmem_addr, dmem_wdata} !== {1'b1, 10'h020, 12'h222}) begin
      n_err++; $display("FAIL b2b_head_b: got we=%b %h/%h required we=1 020/222", write_enable_EC, dmem_addr, dmem_wdata);
    end
    tick();
    set_bubble(); dmem_ack = 1'b1;
    tick();
    n_vec++;
    if ({dmem_req, dmem_addr, dmem_wdata} !== {1'b1, 10'h030, 12'h333}) begin
      n_err++; $display("FAIL b2b_head_c: got req=%b %h/%h required req=1 030/333", dmem_req, dmem_addr, dmem_wdata);
    end
    tick();
    dmem_ack = 1'b0; #1;
    n_vec++;
    if (dmem_req !== 1'b0) begin n_err++; $display("FAIL b2b_drained: req got %b required 0", dmem_req); end
  endtask

  task automatic test_halt();
    do_reset();
    set_store(8'h55, 12'h777);
    tick();
    set_bubble(); instruction_EC = 12'hF00; pc_plus_1_EC = 10'h07F; #1;
    n_vec++;
    if ({clear_EC, write_enable_EC} !== 2'b11) begin
      n_err++; $display("FAIL halt_commit: got clear=%b we=%b required 1 1", clear_EC, write_enable_EC);
    end
    tick();
    set_bubble(); #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({clear_EC, write_enable_EC, halted, dmem_req} !== 4'b0001) begin
        n_err++; $display("FAIL halt_drain[%0d]: got clear=%b we=%b halted=%b req=%b required 0 0 0 1", i, clear_EC, write_enable_EC, halted, dmem_req);
      end
      tick();
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tick();
    set_store(8'h66, 12'h888); #1;
    n_vec++;
    if ({halted, halt_pc, write_enable_EC, instret} !== {1'b1, 10'h07F, 1'b0, 16'd2}) begin
      n_err++; $display("FAIL halt_final: got halted=%b pc=%h we=%b instret=%0d required 1 07f 0 2", halted, halt_pc, write_enable_EC, instret);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_store(8'h01, 12'hAAA); tick();
    set_store(8'h02, 12'hBBB); tick();
    n_vec++;
    if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: req got %b required 1", dmem_req); end
    rst = 1'b1; dmem_ack = 1'b1; set_store(8'h03, 12'hCCC);
    tick();
    rst = 1'b0; dmem_ack = 1'b0; set_bubble(); #1;
    n_vec++;
    if ({dmem_req, dmem_addr, dmem_wdata, rf_we, rf_waddr, rf_wdata, instret, halted, halt_pc} !== '0) begin
      n_err++; $display("FAIL rstmid_outputs: req=%b addr=%h data=%h instret=%h required all zero", dmem_req, dmem_addr, dmem_wdata, instret);
    end
    tick();
    n_vec++;
    if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rstmid_discard: req got %b required 0", dmem_req); end
  endtask

  task automatic test_random();
    logic e_req;
    int halted_cnt;
    do_reset();
    halted_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      rst               = ($urandom_range(0, 99) == 0) || (halted_cnt > 3);
      mem_store_EC      = $urandom_range(0, 2) == 0;
      reg_write_en_EC   = $urandom_range(0, 1) == 1;
      reg_write_addr_EC = 4'($urandom);
      execute_result_EC = 12'($urandom);
      case ($urandom_range(0, 29))
        0:       instruction_EC = {4'hF, 8'($urandom)};
        1, 2:    instruction_EC = 12'h000;
        default: instruction_EC = {4'($urandom_range(0, 14)), 8'($urandom)};
      endcase
      pc_plus_1_EC = 10'($urandom);
      dmem_ack     = $urandom_range(0, 1) == 1;
      #1;
      n_vec++;
      if ({write_enable_EC, clear_EC} !== {m_commit(), m_halt()}) begin
        n_err++; $display("FAIL rnd_comb[%0d]: got we=%b clear=%b required %b %b", i, write_enable_EC, clear_EC, m_commit(), m_halt());
      end
      tick();
      halted_cnt = (m_st == 2) ? halted_cnt + 1 : 0;
      e_req = (m_q.size() != 0);
      n_vec++;
      if (dmem_req !== e_req || (e_req && {dmem_addr, dmem_wdata} !== m_q[0])) begin
        n_err++; $display("FAIL rnd_dmem[%0d]: got req=%b %h/%h required req=%b head=%h", i, dmem_req, dmem_addr, dmem_wdata, e_req, e_req ? m_q[0] : 22'h0);
      end
      n_vec++;
      if (rf_we !== m_rf_we || (m_rf_we && {rf_waddr, rf_wdata} !== {m_rf_waddr, m_rf_wdata})) begin
        n_err++; $display("FAIL rnd_rf[%0d]: got we=%b %h/%h required we=%b %h/%h", i, rf_we, rf_waddr, rf_wdata, m_rf_we, m_rf_waddr, m_rf_wdata);
      end
      n_vec++;
      if ({instret, halted, halt_pc} !== {m_instret, (m_st == 2), m_halt_pc}) begin
        n_err++; $display("FAIL rnd_status[%0d]: got instret=%h halted=%b pc=%h required %h %b %h", i, instret, halted, halt_pc, m_instret, (m_st == 2), m_halt_pc);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_instret_wrap();
    do_reset();
    set_bubble(); instruction_EC = 12'h100;
    for (int i = 0; i < 65535; i++) tick();
    n_vec++;
    if (instret !== 16'hFFFF) begin n_err++; $display("FAIL instret_preset: got %h required ffff", instret); end
    tick();
    n_vec++;
    if (instret !== 16'h0000) begin n_err++; $display("FAIL instret_wrap: got %h required 0000", instret); end
    instruction_EC = 12'h000;
    tick();
    n_vec++;
    if (instret !== 16'h0000) begin n_err++; $display("FAIL instret_nop: got %h required 0000", instret); end
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; set_bubble();
    m_st = 0; m_rf_we = 1'b0; m_rf_waddr = '0; m_rf_wdata = '0; m_instret = '0; m_halt_pc = '0;
    test_reset();
    test_rf_write();
    test_store_hold();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    test_random();
    test_instret_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/commit_stage.md
COMMIT_STAGE -- requirements
Module: commit_stage

Interface
REQ-001 Parameter SB_DEPTH, default 2, SHALL set the store-buffer entry count.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-004 mem_store_EC, reg_write_en_EC  in  1 each  SHALL be the store flag and register-write flag held in the execute-commit register.
REQ-005 reg_write_addr_EC  in  4  SHALL be the register writeback address.
REQ-006 execute_result_EC, instruction_EC  in  12 each  SHALL be the result and instruction held in the execute-commit register.
REQ-007 pc_plus_1_EC  in  10  SHALL be the committed instruction's PC+1.
REQ-008 write_enable_EC, clear_EC  out  1 each  SHALL be the load and flush controls driven back to the execute-commit register.
REQ-009 rf_we  out  1, rf_waddr  out  4, rf_wdata  out  12  SHALL be the registered register-file write port.
REQ-010 dmem_req  out  1, dmem_addr  out  10, dmem_wdata  out  12, dmem_ack  in  1  SHALL be the data-memory write handshake.
REQ-011 instret  out  16  SHALL be the retired-instruction count.
REQ-012 halted  out  1, halt_pc  out  10  SHALL report halt status and the PC+1 of the HALT.

Function
REQ-013 An instruction SHALL commit in a cycle when FSM=RUN and ready=1, where ready = !(mem_store_EC && sb_full).
REQ-014 write_enable_EC SHALL equal ready while FSM=RUN, and 0 in DRAIN and HALTED (combinational).
REQ-015 clear_EC SHALL pulse 1 for exactly one cycle: the cycle in which a HALT (opcode 4'hF) commits.
REQ-016 On commit with reg_write_en_EC=1, rf_we/rf_waddr/rf_wdata SHALL present reg_write_addr_EC/execute_result_EC one cycle later for one cycle; rf_we=0 otherwise.
REQ-017 On commit with mem_store_EC=1, the store buffer SHALL push {addr=instruction_EC[7:0] zero-extended to 10 bits, data=execute_result_EC}.
REQ-018 A stall (ready=0) SHALL neither write the register file, push, nor count.
REQ-019 Store buffer SHALL be a FIFO; dmem_req=1 whenever non-empty, with dmem_addr/dmem_wdata from the head held stable until dmem_ack.
REQ-020 dmem_ack with dmem_req=1 SHALL pop the head that cycle; dmem_ack with dmem_req=0 SHALL be ignored.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; push is never accepted when full (pop in the same cycle does not raise ready).
REQ-022 Pointers SHALL wrap modulo SB_DEPTH.
REQ-023 instret SHALL increment by 1 per committed instruction whose instruction_EC != NOP, wrapping 16'hFFFF -> 0.
REQ-024 FSM states: RUN, DRAIN, HALTED; RUN->DRAIN on HALT commit; DRAIN->HALTED when the store buffer is empty; HALTED is terminal until rst.
REQ-025 HALT itself SHALL count in instret and SHALL latch halt_pc=pc_plus_1_EC; halted=1 only in HALTED.
REQ-026 Stores already buffered SHALL continue draining in DRAIN.

Reset
REQ-027 rst SHALL force: FSM=RUN, store buffer empty, dmem_req=0, dmem_addr=0, dmem_wdata=0, rf_we=0, rf_waddr=0, rf_wdata=0, instret=0, halted=0, halt_pc=0, clear_EC=0.
REQ-028 rst mid-handshake SHALL drop dmem_req the next cycle and discard all buffered stores.
REQ-029 Reset SHALL take priority over commit, push, pop and dmem_ack in the same cycle.

Structure
REQ-030 Package common_def SHALL hold NOP, OP_HALT (4'hF), and the commit FSM state enum.
REQ-031 The FIFO SHALL be a sub-module commit_store_buffer (push, pop, head outputs, full, empty).
REQ-032 All top-level outputs except write_enable_EC and clear_EC SHALL be register outputs.

Verification
REQ-033 ADD r3 result 12'h0A5 committed -> next cycle rf_we=1, rf_waddr=3, rf_wdata=12'h0A5; instret=1.
REQ-034 Store result 12'h123, instruction[7:0]=8'h40, dmem_ack held 0 -> dmem_req=1, addr 10'h040, data 12'h123 stable; ack after 5 cycles pops it.
REQ-035 Three back-to-back stores, ack held 0 -> third cycle write_enable_EC=0; after one ack the third store pushes and drains in order.
REQ-036 HALT at pc_plus_1=10'h07F with one store pending -> clear_EC pulse, DRAIN until ack, then halted=1, halt_pc=10'h07F, write_enable_EC=0.
REQ-037 instret preset to 16'hFFFF via 65535 commits, one more non-NOP -> 0; NOP commit -> unchanged.
REQ-038 rst asserted while dmem_req=1 with two buffered entries -> next cycle dmem_req=0, buffer empty, all outputs at reset values.
